divider_8_bits_controller: RTL and testbench



---
 rtl/divider_8_bits_controller.sv | 175 +++++++++++++++++
 tb/tb_divider_8_bits_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/divider_8_bits_controller.sv
// Sequential 8-bit unsigned restoring divider built around the ripple-borrow subtractor.
// Optional macro DIVIDER_ZERO_CHECK_EN: a zero divisor finishes at once and raises DIV_BY_ZERO.

module full_subtractor_1_bit (
  input  logic A,
  input  logic B,
  input  logic BIN,
  output logic DIFF,
  output logic BOUT
);
  assign DIFF = A ^ B ^ BIN;
  assign BOUT = (~A & B) | (~(A ^ B) & BIN);
endmodule

module full_subtractor_8_bits_structure (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       BIN,
  output logic [7:0] DIFF,
  output logic       BOUT
);
  logic [8:0] borrowChain;

  assign borrowChain[0] = BIN;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    full_subtractor_1_bit u_fs (
      .A   (A[i]),
      .B   (B[i]),
      .BIN (borrowChain[i]),
      .DIFF(DIFF[i]),
      .BOUT(borrowChain[i+1])
    );
  end

  assign BOUT = borrowChain[8];
endmodule

module divider_8_bits_controller (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] DIVIDEND,
  input  logic [7:0] DIVISOR,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] QUOTIENT,
  output logic [7:0] REMAINDER,
  output logic       DIV_BY_ZERO
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t     state_q;
  logic [7:0] partRem_q;
  logic [7:0] quoShift_q;
  logic [7:0] divisor_q;
  logic [2:0] count_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] quotient_q;
  logic [7:0] remainder_q;
`ifdef DIVIDER_ZERO_CHECK_EN
  logic       divByZero_q;
`endif

  logic [7:0] trial_d;
  logic [7:0] diff_d;
  logic       borrow_d;
  logic       accept_d;
  logic [7:0] partRem_d;
  logic [7:0] quoShift_d;

  // R[7] acts as the ninth bit of the shifted remainder, so a set bit always fits.
  assign trial_d    = {partRem_q[6:0], quoShift_q[7]};
  assign accept_d   = partRem_q[7] | ~borrow_d;
  assign partRem_d  = accept_d ? diff_d : trial_d;
  assign quoShift_d = {quoShift_q[6:0], accept_d};

  full_subtractor_8_bits_structure u_sub (
    .A   (trial_d),
    .B   (divisor_q),
    .BIN (1'b0),
    .DIFF(diff_d),
    .BOUT(borrow_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      partRem_q   <= 8'h00;
      quoShift_q  <= 8'h00;
      divisor_q   <= 8'h00;
      count_q     <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= 8'h00;
      remainder_q <= 8'h00;
`ifdef DIVIDER_ZERO_CHECK_EN
      divByZero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (START) begin
`ifdef DIVIDER_ZERO_CHECK_EN
            if (DIVISOR == 8'h00) begin
              quotient_q  <= 8'hFF;
              remainder_q <= DIVIDEND;
              divByZero_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= FINISH;
            end else begin
              divisor_q  <= DIVISOR;
              quoShift_q <= DIVIDEND;
              partRem_q  <= 8'h00;
              count_q    <= 3'd0;
              busy_q     <= 1'b1;
              state_q    <= RUN;
            end
`else
            divisor_q  <= DIVISOR;
            quoShift_q <= DIVIDEND;
            partRem_q  <= 8'h00;
            count_q    <= 3'd0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
`endif
          end
        end
        RUN: begin
          partRem_q  <= partRem_d;
          quoShift_q <= quoShift_d;
          count_q    <= count_q + 3'd1;
          // Results are captured from the final iteration's next values, not the registers.
          if (count_q == 3'd7) begin
            quotient_q  <= quoShift_d;
            remainder_q <= partRem_d;
`ifdef DIVIDER_ZERO_CHECK_EN
            divByZero_q <= 1'b0;
`endif
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= FINISH;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign QUOTIENT  = quotient_q;
  assign REMAINDER = remainder_q;
`ifdef DIVIDER_ZERO_CHECK_EN
  assign DIV_BY_ZERO = divByZero_q;
`else
  assign DIV_BY_ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_divider_8_bits_controller.sv
// Scoreboard bench for divider_8_bits_controller: driver queues arithmetic expectations, monitor checks them.

module tb_divider_8_bits_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] DIVIDEND;
  logic [7:0] DIVISOR;
  logic       BUSY;
  logic       DONE;
  logic [7:0] QUOTIENT;
  logic [7:0] REMAINDER;
  logic       DIV_BY_ZERO;

`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZeroChk = 1'b1;
`else
  localparam bit ZeroChk = 1'b0;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         edgeNo;
  } exp_t;

  exp_t       sbQ[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] heldQ = 8'h00;
  logic [7:0] heldR = 8'h00;
  logic       heldZ = 1'b0;
  int         opStart = -100;
  bit         opActive = 1'b0;
  bit         opZero = 1'b0;
  int         nextFree = 0;
  bit         monEnable = 1'b0;

  divider_8_bits_controller dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .DIVIDEND   (DIVIDEND),
    .DIVISOR    (DIVISOR),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .QUOTIENT   (QUOTIENT),
    .REMAINDER  (REMAINDER),
    .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endfunction

  // Monitor: samples just after each rising edge and compares against the scoreboard.
  always @(posedge CLK) begin : monitor
    exp_t e;
    bit   expBusy;
    #1;
    cyc++;
    if (!RST && monEnable) begin
      expBusy = opActive && !opZero && (cyc >= opStart) && (cyc <= opStart + 7);
      checkOutput("busy", int'(BUSY), int'(expBusy));
      if (DONE) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", sbQ.size(), 1);
        end else begin
          e = sbQ.pop_front();
          checkOutput("quotient", int'(QUOTIENT), int'(e.q));
          checkOutput("remainder", int'(REMAINDER), int'(e.r));
          checkOutput("div_by_zero", int'(DIV_BY_ZERO), int'(e.z));
          checkOutput("done_edge", cyc, e.edgeNo);
          heldQ = e.q;
          heldR = e.r;
          heldZ = e.z;
        end
      end else begin
        checkOutput("held_quotient", int'(QUOTIENT), int'(heldQ));
        checkOutput("held_remainder", int'(REMAINDER), int'(heldR));
        checkOutput("held_div_by_zero", int'(DIV_BY_ZERO), int'(heldZ));
      end
    end
  end

  // Issues one START at the earliest legal edge and queues the arithmetic expectation.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    bit   zeroPath;
    @(negedge CLK);
    while (cyc + 1 < nextFree) @(negedge CLK);
    DIVIDEND = a;
    DIVISOR  = b;
    START    = 1'b1;
    if (b == 8'h00) begin
      e.q = 8'hFF;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    zeroPath = ZeroChk && (b == 8'h00);
    e.z      = zeroPath;
    e.edgeNo = cyc + 1 + (zeroPath ? 0 : 8);
    opStart  = cyc + 1;
    opZero   = zeroPath;
    opActive = 1'b1;
    nextFree = cyc + 1 + (zeroPath ? 2 : 10);
    sbQ.push_back(e);
    @(negedge CLK);
    START    = 1'b0;
    DIVIDEND = 8'($urandom);
    DIVISOR  = 8'($urandom);
  endtask

  initial begin
    int guard;
    logic [7:0] ra;
    logic [7:0] rb;
    RST      = 1'b1;
    START    = 1'b0;
    DIVIDEND = 8'h00;
    DIVISOR  = 8'h00;
    repeat (2) @(negedge CLK);
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_done", int'(DONE), 0);
    checkOutput("reset_quotient", int'(QUOTIENT), 0);
    checkOutput("reset_remainder", int'(REMAINDER), 0);
    checkOutput("reset_div_by_zero", int'(DIV_BY_ZERO), 0);
    RST       = 1'b0;
    monEnable = 1'b1;
    nextFree  = cyc + 1;

    applyStimulus(8'd200, 8'd7);
    applyStimulus(8'd255, 8'd1);
    applyStimulus(8'd5, 8'd9);
    applyStimulus(8'd15, 8'd2);
    applyStimulus(8'd100, 8'd0);
    applyStimulus(8'd128, 8'd255);

    // A second START while running must be ignored.
    applyStimulus(8'd200, 8'd7);
    repeat (2) @(negedge CLK);
    DIVIDEND = 8'd10;
    DIVISOR  = 8'd3;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;

    // Reset mid-operation aborts and clears held results.
    applyStimulus(8'd200, 8'd7);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("abort_busy", int'(BUSY), 0);
    checkOutput("abort_done", int'(DONE), 0);
    checkOutput("abort_quotient", int'(QUOTIENT), 0);
    checkOutput("abort_remainder", int'(REMAINDER), 0);
    checkOutput("abort_div_by_zero", int'(DIV_BY_ZERO), 0);
    sbQ.delete();
    heldQ    = 8'h00;
    heldR    = 8'h00;
    heldZ    = 1'b0;
    opActive = 1'b0;
    @(negedge CLK);
    RST      = 1'b0;
    nextFree = cyc + 1;
    applyStimulus(8'd10, 8'd3);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      applyStimulus(ra, rb);
    end

    guard = 0;
    while (sbQ.size() > 0 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    if (sbQ.size() > 0) checkOutput("drain_timeout", sbQ.size(), 0);
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
